uflash_boot_copier: RTL and testbench
=====================================

Name: uflash_boot_copier

Overview:
Bus initiator that drives the user-flash controller's PicoRV32-style slave port and copies a flash-resident image into SRAM at power-up. It holds the CPU in reset until the copy finishes.
- Flash image layout, starting at word address SRC_BASE:
  - Header word: [31:16] = 16'hB007 magic, [15:0] = payload word count N.
  - N payload words.
  - One 32-bit additive checksum word.
- Sits between the flash controller, the SRAM bus and the CPU reset logic in the Tang Nano 9K top level.

Parameters:
SRC_BASE, 15'd0, flash word address of the header word
DST_BASE, 32'h0000_0000, SRAM byte address receiving payload word 0
MAX_WORDS, 16'd8192, largest accepted N; above this is an error
FLASH_WORDS, 19456, flash size in 32-bit words (608 Kbit)
AUTO_START, 1, 1 = begin copy on the first cycle after reset; 0 = wait for start

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle start pulse; used only when AUTO_START=0
fl_sel  out  1  flash request; held until fl_ready
fl_wstrb  out  4  always 4'b0000 (read-only initiator)
fl_addr  out  15  flash word address
fl_rdata  in  32  flash read data, sampled on the fl_ready cycle
fl_ready  in  1  one-cycle completion pulse from the flash controller
mem_valid  out  1  SRAM write request; held until mem_ready
mem_addr  out  32  SRAM byte address
mem_wdata  out  32  SRAM write data
mem_wstrb  out  4  always 4'b1111 while mem_valid is high
mem_ready  in  1  SRAM completion pulse
cpu_hold  out  1  1 = keep CPU in reset
busy  out  1  copy in progress
done  out  1  sticky; copy completed and checksum matched
error  out  1  sticky; bad magic, length, range or checksum

Behaviour:
Outputs and reset
- All outputs are registered.
- Values after reset: fl_sel=0, fl_addr=SRC_BASE, mem_valid=0, busy=0, done=0, error=0, cpu_hold=1.
- Reset asserted mid-operation: the next edge returns to IDLE, drops fl_sel and mem_valid, and clears done and error.

States: IDLE, HDR, CHK, RD, WR, SUM, FIN, FAIL.
- IDLE:
  - Go to HDR when AUTO_START=1 (first cycle out of reset) or when start=1.
  - On entry to HDR: fl_sel<=1, fl_addr<=SRC_BASE, busy<=1.
  - start is ignored in every state except IDLE.
- HDR:
  - Wait for fl_ready. On that edge: capture fl_rdata, fl_sel<=0, go to CHK.
  - fl_sel must be low on the cycle after fl_ready, so the controller does not re-trigger from its IDLE state.
- CHK (one cycle):
  - Go to FAIL if magic != 16'hB007, or N > MAX_WORDS, or SRC_BASE+N+2 > FLASH_WORDS (17-bit compare).
  - Otherwise go to SUM if N==0, else RD.
  - Clear idx and the running sum (32 bits).
- RD:
  - Issue fl_sel with fl_addr = SRC_BASE+1+idx.
  - On fl_ready: latch the data, sum <= sum + data (mod 2^32), fl_sel<=0, go to WR.
- WR:
  - Set mem_valid=1, mem_addr = DST_BASE + 4*idx, mem_wdata = the latched word.
  - On mem_ready: mem_valid<=0 and idx<=idx+1.
  - Go to SUM if idx+1==N, else RD.
- SUM:
  - Read address SRC_BASE+1+N.
  - On fl_ready: go to FIN if fl_rdata==sum, else FAIL.
- FIN: done<=1, busy<=0, cpu_hold<=0. The block stays in FIN until reset.
- FAIL: error<=1, busy<=0.
  - cpu_hold stays 1 (CPU never runs a bad image).
  - The block stays in FAIL until reset.
  - A checksum failure happens after the SRAM writes; the SRAM contents are left as written.

Bus and timing rules
- fl_sel and mem_valid are never high in the same cycle.
- Each request is held stable (address and data) until its ready pulse.
- There is no timeout. A ready that never arrives stalls the block in RD/WR/HDR/SUM.
- Latency for N words: ~(N+2) flash reads plus N SRAM writes plus 2 cycles; each flash read is about 4 cycles.

Decomposition:
- Shared package holds the state encoding, BOOT_MAGIC=16'hB007 and FLASH_WORDS.
- No sub-module: a single FSM with an idx counter and a sum accumulator.

Test Plan:
- Header 32'hB007_0003, payload {1,2,3}, checksum 6:
  - Exactly three SRAM writes: (DST_BASE,1), (+4,2), (+8,3).
  - Then done=1, cpu_hold=0, error=0.
- Header 32'hB007_0000, checksum word 0:
  - No mem_valid pulses.
  - done=1 after 2 flash reads.
- Header 32'h1234_0003:
  - error=1 and cpu_hold=1 after the header read only.
  - No further fl_sel, no SRAM writes.
- N=3, checksum word 7 (true sum 6):
  - Three writes complete, then error=1, done=0, cpu_hold=1.
- Protocol and stall checks:
  - Flash model checks fl_sel==0 on the cycle after every fl_ready.
  - SRAM model stalls mem_ready 5 cycles; mem_addr and mem_wdata must stay stable throughout.
- Reset and start handling:
  - Assert reset during the second WR: fl_sel=0, mem_valid=0, busy=0 next cycle.
  - With AUTO_START=0, start pulse restarts the full copy from the header.

Source files
------------

// File: rtl/uflash_boot_copier_pkg.sv
// Shared definitions for the boot copier: FSM encoding, image magic and flash geometry.
package uflash_boot_copier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CHK,
        ST_RD,
        ST_WR,
        ST_SUM,
        ST_FIN,
        ST_FAIL
    } state_e;

    localparam logic [15:0] BOOT_MAGIC  = 16'hB007;
    localparam int          FLASH_WORDS = 19456;
    localparam int          FL_AW       = 15;

    // Header-relative flash word address; the header check guarantees no wrap.
    function automatic logic [FL_AW-1:0] flash_word_addr(input logic [FL_AW-1:0] base,
                                                         input logic [15:0] offset);
        return base + 15'(offset);
    endfunction

endpackage

// File: rtl/uflash_boot_copier_if.sv
// Flash read port and SRAM write port driven by the boot copier.
interface uflash_boot_copier_if;
    import uflash_boot_copier_pkg::*;

    logic             fl_sel;
    logic [3:0]       fl_wstrb;
    logic [FL_AW-1:0] fl_addr;
    logic [31:0]      fl_rdata;
    logic             fl_ready;

    logic             mem_valid;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready;

    modport master (
        output fl_sel, fl_wstrb, fl_addr, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  fl_rdata, fl_ready, mem_ready
    );

    modport slave (
        input  fl_sel, fl_wstrb, fl_addr, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output fl_rdata, fl_ready, mem_ready
    );

endinterface

// File: rtl/uflash_boot_copier.sv
// Copies a checksummed flash image into SRAM after reset and releases the CPU only
// when the whole image has been written and its checksum matches.
module uflash_boot_copier
    import uflash_boot_copier_pkg::*;
#(
    parameter logic [FL_AW-1:0] SRC_BASE   = 15'd0,
    parameter logic [31:0]      DST_BASE   = 32'h0000_0000,
    parameter logic [15:0]      MAX_WORDS  = 16'd8192,
    parameter bit               AUTO_START = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    uflash_boot_copier_if.master        bus,
    output logic                        cpu_hold_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o
);

    state_e           state_q, state_d;
    logic             fl_sel_q, fl_sel_d;
    logic [FL_AW-1:0] fl_addr_q, fl_addr_d;
    logic             mem_valid_q, mem_valid_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic [31:0]      hdr_q, hdr_d;
    logic [15:0]      idx_q, idx_d;
    logic [31:0]      sum_q, sum_d;

    logic [15:0] hdrN;
    logic [16:0] imageEnd;
    logic        headerBad;
    logic [15:0] idxNext;

    assign hdrN      = hdr_q[15:0];
    assign imageEnd  = {2'b00, SRC_BASE} + {1'b0, hdrN} + 17'd2;
    assign headerBad = (hdr_q[31:16] != BOOT_MAGIC) || (hdrN > MAX_WORDS) ||
                       (imageEnd > 17'(FLASH_WORDS));
    assign idxNext   = idx_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fl_sel_q    <= 1'b0;
            fl_addr_q   <= SRC_BASE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= DST_BASE;
            mem_wdata_q <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= 1'b1;
            hdr_q       <= 32'h0;
            idx_q       <= 16'h0;
            sum_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            fl_sel_q    <= fl_sel_d;
            fl_addr_q   <= fl_addr_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_hold_q  <= cpu_hold_d;
            hdr_q       <= hdr_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
        end
    end

    // Each request is set up on the transition into its state so the bus outputs
    // come straight from registers and stay stable until the matching ready pulse.
    always_comb begin
        state_d     = state_q;
        fl_sel_d    = fl_sel_q;
        fl_addr_d   = fl_addr_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_hold_d  = cpu_hold_q;
        hdr_d       = hdr_q;
        idx_d       = idx_q;
        sum_d       = sum_q;

        case (state_q)
            ST_IDLE: begin
                if (AUTO_START || start_i) begin
                    state_d   = ST_HDR;
                    fl_sel_d  = 1'b1;
                    fl_addr_d = SRC_BASE;
                    busy_d    = 1'b1;
                end
            end
            ST_HDR: begin
                if (bus.fl_ready) begin
                    hdr_d    = bus.fl_rdata;
                    fl_sel_d = 1'b0;
                    state_d  = ST_CHK;
                end
            end
            ST_CHK: begin
                idx_d = 16'h0;
                sum_d = 32'h0;
                if (headerBad) begin
                    state_d = ST_FAIL;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else if (hdrN == 16'h0) begin
                    state_d   = ST_SUM;
                    fl_sel_d  = 1'b1;
                    fl_addr_d = flash_word_addr(SRC_BASE, hdrN + 16'd1);
                end else begin
                    state_d   = ST_RD;
                    fl_sel_d  = 1'b1;
                    fl_addr_d = flash_word_addr(SRC_BASE, 16'd1);
                end
            end
            ST_RD: begin
                if (bus.fl_ready) begin
                    sum_d       = sum_q + bus.fl_rdata;
                    fl_sel_d    = 1'b0;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = DST_BASE + {14'b0, idx_q, 2'b00};
                    mem_wdata_d = bus.fl_rdata;
                    state_d     = ST_WR;
                end
            end
            ST_WR: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    idx_d       = idxNext;
                    fl_sel_d    = 1'b1;
                    if (idxNext == hdrN) begin
                        state_d   = ST_SUM;
                        fl_addr_d = flash_word_addr(SRC_BASE, hdrN + 16'd1);
                    end else begin
                        state_d   = ST_RD;
                        fl_addr_d = flash_word_addr(SRC_BASE, idxNext + 16'd1);
                    end
                end
            end
            ST_SUM: begin
                if (bus.fl_ready) begin
                    fl_sel_d = 1'b0;
                    busy_d   = 1'b0;
                    if (bus.fl_rdata == sum_q) begin
                        state_d    = ST_FIN;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ST_FAIL;
                        error_d = 1'b1;
                    end
                end
            end
            ST_FIN, ST_FAIL: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.fl_sel    = fl_sel_q;
    assign bus.fl_wstrb  = 4'b0000;
    assign bus.fl_addr   = fl_addr_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = {4{mem_valid_q}};
    assign cpu_hold_o    = cpu_hold_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_uflash_boot_copier.sv
// Bench for uflash_boot_copier: instance A auto-starts against a slow flash and a
// stalling SRAM; instance B waits for start and sits at the top of the flash.
module tb_uflash_boot_copier;
    import uflash_boot_copier_pkg::*;

    localparam logic [14:0] SRC_A     = 15'd4;
    localparam logic [31:0] DST_A     = 32'h0000_1000;
    localparam logic [15:0] MAX_A     = 16'd8;
    localparam logic [14:0] SRC_B     = 15'd19450;
    localparam logic [31:0] DST_B     = 32'h2000_0000;
    localparam int          FL_LAT    = 3;
    localparam int          MEM_STALL = 5;
    localparam int          TIMEOUT   = 2000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetA, resetB, startA, startB;
    logic holdA, busyA, doneA, errorA;
    logic holdB, busyB, doneB, errorB;

    uflash_boot_copier_if busA ();
    uflash_boot_copier_if busB ();

    uflash_boot_copier #(
        .SRC_BASE(SRC_A), .DST_BASE(DST_A), .MAX_WORDS(MAX_A), .AUTO_START(1'b1)
    ) dutA (
        .clk(clk), .reset(resetA), .start_i(startA), .bus(busA),
        .cpu_hold_o(holdA), .busy_o(busyA), .done_o(doneA), .error_o(errorA)
    );

    uflash_boot_copier #(
        .SRC_BASE(SRC_B), .DST_BASE(DST_B), .MAX_WORDS(16'd8192), .AUTO_START(1'b0)
    ) dutB (
        .clk(clk), .reset(resetB), .start_i(startB), .bus(busB),
        .cpu_hold_o(holdB), .busy_o(busyB), .done_o(doneB), .error_o(errorB)
    );

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] flashA [0:31];
    logic [31:0] flashB [0:7];
    wr_t sbA[$];
    wr_t sbB[$];

    int flWaitA, memWaitA, flReadsA, wrCountA, overlapA, protoErrA;
    int firstRdA, lastRdA, flReadsB, wrCountB, firstRdB;
    logic [14:0] flAddrHoldA;
    logic [31:0] memAddrHoldA, memDataHoldA;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Slow flash (FL_LAT wait cycles) and SRAM stalling MEM_STALL cycles for instance A.
    always @(negedge clk) begin
        if (resetA) begin
            busA.fl_ready  = 1'b0;
            busA.mem_ready = 1'b0;
            flWaitA = 0; memWaitA = 0; flReadsA = 0; wrCountA = 0;
            overlapA = 0; protoErrA = 0;
        end else begin
            if (busA.fl_sel && busA.mem_valid) overlapA++;
            if (busA.fl_ready) begin
                busA.fl_ready = 1'b0;
                checkOutput("A.flSelDrop", 32'(busA.fl_sel), 0);
            end else if (busA.fl_sel) begin
                if (busA.fl_wstrb != 4'b0000) protoErrA++;
                if (flWaitA == 0) flAddrHoldA = busA.fl_addr;
                else if (busA.fl_addr !== flAddrHoldA) protoErrA++;
                if (flWaitA == FL_LAT) begin
                    busA.fl_ready = 1'b1;
                    busA.fl_rdata = flashA[busA.fl_addr[4:0]];
                    if (flReadsA == 0) firstRdA = 32'(busA.fl_addr);
                    lastRdA = 32'(busA.fl_addr);
                    flReadsA++;
                    flWaitA = 0;
                end else begin
                    flWaitA++;
                end
            end
            if (busA.mem_ready) begin
                busA.mem_ready = 1'b0;
            end else if (busA.mem_valid) begin
                if (busA.mem_wstrb != 4'b1111) protoErrA++;
                if (memWaitA == 0) begin
                    memAddrHoldA = busA.mem_addr;
                    memDataHoldA = busA.mem_wdata;
                end else if (busA.mem_addr !== memAddrHoldA || busA.mem_wdata !== memDataHoldA) begin
                    protoErrA++;
                end
                if (memWaitA == MEM_STALL) begin
                    wr_t e;
                    busA.mem_ready = 1'b1;
                    wrCountA++;
                    memWaitA = 0;
                    checkOutput("A.sbDepth", 32'(sbA.size() > 0), 1);
                    if (sbA.size() > 0) begin
                        e = sbA.pop_front();
                        checkOutput("A.wrAddr", busA.mem_addr, e.addr);
                        checkOutput("A.wrData", busA.mem_wdata, e.data);
                    end
                end else begin
                    memWaitA++;
                end
            end
        end
    end

    // Single-cycle flash and SRAM for instance B.
    always @(negedge clk) begin
        if (resetB) begin
            busB.fl_ready  = 1'b0;
            busB.mem_ready = 1'b0;
            flReadsB = 0; wrCountB = 0;
        end else begin
            if (busB.fl_ready) begin
                busB.fl_ready = 1'b0;
            end else if (busB.fl_sel) begin
                busB.fl_ready = 1'b1;
                busB.fl_rdata = flashB[3'(busB.fl_addr - SRC_B)];
                if (flReadsB == 0) firstRdB = 32'(busB.fl_addr);
                flReadsB++;
            end
            if (busB.mem_ready) begin
                busB.mem_ready = 1'b0;
            end else if (busB.mem_valid) begin
                wr_t e;
                busB.mem_ready = 1'b1;
                wrCountB++;
                checkOutput("B.sbDepth", 32'(sbB.size() > 0), 1);
                if (sbB.size() > 0) begin
                    e = sbB.pop_front();
                    checkOutput("B.wrAddr", busB.mem_addr, e.addr);
                    checkOutput("B.wrData", busB.mem_wdata, e.data);
                end
            end
        end
    end

    // Loads an image (payload firstWord + i*step), queues the expected SRAM writes,
    // then pulses reset on the chosen instance.
    task automatic applyStimulus(input bit onB, input logic [31:0] header, input int nWords,
                                 input logic [31:0] firstWord, input logic [31:0] step,
                                 input logic [31:0] sumOffset, input bit expectWrites);
        logic [31:0] sum;
        logic [31:0] w;
        sum = 32'h0;
        if (onB) begin resetB = 1'b1; sbB.delete(); flashB[0] = header; end
        else     begin resetA = 1'b1; sbA.delete(); flashA[int'(SRC_A)] = header; end
        for (int i = 0; i < nWords; i++) begin
            w = firstWord + step * 32'(i);
            sum = sum + w;
            if (onB) begin
                flashB[1 + i] = w;
                if (expectWrites) sbB.push_back('{addr: DST_B + 32'(4 * i), data: w});
            end else begin
                flashA[int'(SRC_A) + 1 + i] = w;
                if (expectWrites) sbA.push_back('{addr: DST_A + 32'(4 * i), data: w});
            end
        end
        if (onB) flashB[1 + nWords] = sum + sumOffset;
        else     flashA[int'(SRC_A) + 1 + nWords] = sum + sumOffset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (onB) resetB = 1'b0;
        else     resetA = 1'b0;
    endtask

    task automatic waitFinish(input bit onB);
        logic fin;
        fin = 1'b0;
        for (int c = 0; c < TIMEOUT && !fin; c++) begin
            @(posedge clk); #1;
            fin = onB ? (doneB | errorB) : (doneA | errorA);
        end
        checkOutput(onB ? "B.finish" : "A.finish", 32'(fin), 1);
    endtask

    task automatic checkResult(input bit onB, input logic expDone, input logic expErr,
                               input int expReads, input int expWrites);
        repeat (20) @(posedge clk);
        #1;
        if (onB) begin
            checkOutput("B.done", 32'(doneB), 32'(expDone));
            checkOutput("B.error", 32'(errorB), 32'(expErr));
            checkOutput("B.hold", 32'(holdB), 32'(!expDone));
            checkOutput("B.busy", 32'(busyB), 0);
            checkOutput("B.reads", flReadsB, expReads);
            checkOutput("B.writes", wrCountB, expWrites);
            checkOutput("B.sbLeft", sbB.size(), 0);
            checkOutput("B.firstRd", firstRdB, 32'(SRC_B));
        end else begin
            checkOutput("A.done", 32'(doneA), 32'(expDone));
            checkOutput("A.error", 32'(errorA), 32'(expErr));
            checkOutput("A.hold", 32'(holdA), 32'(!expDone));
            checkOutput("A.busy", 32'(busyA), 0);
            checkOutput("A.reads", flReadsA, expReads);
            checkOutput("A.writes", wrCountA, expWrites);
            checkOutput("A.sbLeft", sbA.size(), 0);
            checkOutput("A.firstRd", firstRdA, 32'(SRC_A));
            checkOutput("A.overlap", overlapA, 0);
            checkOutput("A.protocol", protoErrA, 0);
        end
    endtask

    task automatic pulseStart();
        @(negedge clk); startB = 1'b1;
        @(negedge clk); startB = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetA = 1'b1; resetB = 1'b1; startA = 1'b0; startB = 1'b0;
        for (int i = 0; i < 32; i++) flashA[i] = 32'hDEAD_0000 | 32'(i);
        for (int i = 0; i < 8; i++)  flashB[i] = 32'hBEEF_0000 | 32'(i);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("A.rstSel", 32'(busA.fl_sel), 0);
        checkOutput("A.rstAddr", 32'(busA.fl_addr), 32'(SRC_A));
        checkOutput("A.rstValid", 32'(busA.mem_valid), 0);
        checkOutput("A.rstBusy", 32'(busyA), 0);
        checkOutput("A.rstDone", 32'(doneA), 0);
        checkOutput("A.rstError", 32'(errorA), 0);
        checkOutput("A.rstHold", 32'(holdA), 1);

        applyStimulus(1'b0, 32'hB007_0003, 3, 32'd1, 32'd1, 32'd0, 1'b1);
        waitFinish(1'b0);
        checkResult(1'b0, 1'b1, 1'b0, 5, 3);
        checkOutput("A.sumAddr", lastRdA, 32'(SRC_A) + 32'd4);

        applyStimulus(1'b0, 32'hB007_0000, 0, 32'd0, 32'd0, 32'd0, 1'b1);
        waitFinish(1'b0);
        checkResult(1'b0, 1'b1, 1'b0, 2, 0);

        applyStimulus(1'b0, 32'h1234_0003, 3, 32'd1, 32'd1, 32'd0, 1'b0);
        waitFinish(1'b0);
        checkResult(1'b0, 1'b0, 1'b1, 1, 0);

        applyStimulus(1'b0, 32'hB007_0003, 3, 32'd1, 32'd1, 32'd1, 1'b1);
        waitFinish(1'b0);
        checkResult(1'b0, 1'b0, 1'b1, 5, 3);

        applyStimulus(1'b0, 32'hB007_0006, 6, $urandom, $urandom, 32'd0, 1'b1);
        waitFinish(1'b0);
        checkResult(1'b0, 1'b1, 1'b0, 8, 6);

        applyStimulus(1'b0, 32'hB007_0008, 8, $urandom, 32'h0101_0101, 32'd0, 1'b1);
        waitFinish(1'b0);
        checkResult(1'b0, 1'b1, 1'b0, 10, 8);

        applyStimulus(1'b0, 32'hB007_0009, 9, 32'd5, 32'd3, 32'd0, 1'b0);
        waitFinish(1'b0);
        checkResult(1'b0, 1'b0, 1'b1, 1, 0);

        applyStimulus(1'b0, 32'hB007_0003, 3, 32'd1, 32'd1, 32'd0, 1'b1);
        for (int c = 0; c < TIMEOUT && !(wrCountA == 1 && busA.mem_valid); c++) begin
            @(posedge clk); #1;
        end
        checkOutput("A.secondWr", 32'(busA.mem_valid), 1);
        @(negedge clk); resetA = 1'b1;
        @(posedge clk); #1;
        checkOutput("A.midRstSel", 32'(busA.fl_sel), 0);
        checkOutput("A.midRstValid", 32'(busA.mem_valid), 0);
        checkOutput("A.midRstBusy", 32'(busyA), 0);
        checkOutput("A.midRstHold", 32'(holdA), 1);

        applyStimulus(1'b1, 32'hB007_0004, 4, $urandom, $urandom, 32'd0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("B.idleBusy", 32'(busyB), 0);
        checkOutput("B.idleReads", flReadsB, 0);
        pulseStart();
        for (int c = 0; c < TIMEOUT && wrCountB < 2; c++) begin
            @(posedge clk); #1;
        end
        checkOutput("B.midCopy", wrCountB, 2);
        @(negedge clk); resetB = 1'b1;
        @(posedge clk); #1;
        checkOutput("B.midRstBusy", 32'(busyB), 0);
        checkOutput("B.midRstSel", 32'(busB.fl_sel), 0);

        applyStimulus(1'b1, 32'hB007_0004, 4, $urandom, $urandom, 32'd0, 1'b1);
        pulseStart();
        waitFinish(1'b1);
        checkResult(1'b1, 1'b1, 1'b0, 6, 4);
        pulseStart();
        repeat (10) @(posedge clk);
        #1;
        checkOutput("B.startIgnored", flReadsB, 6);
        checkOutput("B.stillDone", 32'(doneB), 1);

        applyStimulus(1'b1, 32'hB007_0005, 5, 32'd9, 32'd2, 32'd0, 1'b0);
        pulseStart();
        waitFinish(1'b1);
        checkResult(1'b1, 1'b0, 1'b1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
